// File: rtl/pipelined_cla_adder_if.sv
// Operand/result bundle for pipelined_cla_adder.
// The optional sub signal exists only when PIPE_CLA_SUB_EN is defined.
interface pipelined_cla_adder_if #(
  parameter int WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             cin;
`ifdef PIPE_CLA_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic             cout;
  logic             ovf;

  // Producer/consumer side (testbench or upstream logic).
  modport master (
`ifdef PIPE_CLA_SUB_EN
    output sub,
`endif
    output in_valid, A, B, cin, out_ready,
    input  in_ready, out_valid, S, cout, ovf
  );

  // Adder side.
  modport slave (
`ifdef PIPE_CLA_SUB_EN
    input  sub,
`endif
    input  in_valid, A, B, cin, out_ready,
    output in_ready, out_valid, S, cout, ovf
  );
endinterface

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder: WIDTH-bit add done CHUNK bits per stage,
// each slice built from 4-bit CLA groups, with a registered carry between
// stages and a single global advance enable for valid/ready flow control.
// Optional subtract support is compiled in with PIPE_CLA_SUB_EN.
// WIDTH must be a multiple of CHUNK, and CHUNK a multiple of 4.
module pipelined_cla_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  pipelined_cla_adder_if.slave bus
);

  localparam int N  = WIDTH / CHUNK;  // pipeline stages
  localparam int NG = CHUNK / 4;      // 4-bit CLA groups per slice

  logic en;
  logic out_valid_w;

  // Every stage shifts together whenever the output slot is free or drained.
  assign en          = ~out_valid_w | bus.out_ready;
  assign bus.in_ready = en;

  genvar gi, gj;
  generate
    for (gi = 0; gi < N; gi++) begin : g_stage
      // Operand bits still to be added at this stage's input (low CHUNK bits
      // are this stage's slice), and sum bits finished after this stage.
      localparam int RW = WIDTH - gi * CHUNK;
      localparam int SW = (gi + 1) * CHUNK;

      logic             v_in;
      logic [RW-1:0]    a_in;
      logic [RW-1:0]    b_in;
      logic             c_in;
`ifdef PIPE_CLA_SUB_EN
      logic             sub_in;
`endif
      logic [CHUNK-1:0] sb;
      logic [CHUNK-1:0] p;
      logic [CHUNK-1:0] g;
      logic [CHUNK-1:0] c;          // carry into each bit of the slice
      logic [CHUNK-1:0] slice_sum;
      logic             slice_cout;
      logic [SW-1:0]    sum_d;

      logic             valid_q;
      logic [SW-1:0]    sum_q;
      logic             carry_q;

      // Stage inputs: the bus for stage 0, the previous stage register otherwise.
      if (gi == 0) begin : g_src
        assign v_in  = bus.in_valid;
        assign a_in  = bus.A;
        assign b_in  = bus.B;
`ifdef PIPE_CLA_SUB_EN
        assign sub_in = bus.sub;
        // Subtraction is A + ~B + 1, so the external carry is overridden.
        assign c_in   = bus.sub | bus.cin;
`else
        assign c_in   = bus.cin;
`endif
        assign sum_d = slice_sum;
      end else begin : g_src
        assign v_in  = g_stage[gi-1].valid_q;
        assign a_in  = g_stage[gi-1].g_fwd.a_fwd_q;
        assign b_in  = g_stage[gi-1].g_fwd.b_fwd_q;
`ifdef PIPE_CLA_SUB_EN
        assign sub_in = g_stage[gi-1].g_fwd.sub_fwd_q;
`endif
        assign c_in  = g_stage[gi-1].carry_q;
        assign sum_d = {slice_sum, g_stage[gi-1].sum_q};
      end

`ifdef PIPE_CLA_SUB_EN
      assign sb = sub_in ? ~b_in[CHUNK-1:0] : b_in[CHUNK-1:0];
`else
      assign sb = b_in[CHUNK-1:0];
`endif
      assign p = a_in[CHUNK-1:0] ^ sb;
      assign g = a_in[CHUNK-1:0] & sb;

      // 4-bit CLA groups; group P/G chain the carry from group to group.
      for (gj = 0; gj < NG; gj++) begin : g_grp
        logic [3:0] gp;
        logic [3:0] gg;
        logic       ci;
        logic       grp_p;
        logic       grp_g;
        logic       co;

        if (gj == 0) begin : g_ci
          assign ci = c_in;
        end else begin : g_ci
          assign ci = g_grp[gj-1].co;
        end

        assign gp = p[4*gj +: 4];
        assign gg = g[4*gj +: 4];

        assign c[4*gj]   = ci;
        assign c[4*gj+1] = gg[0] | (gp[0] & ci);
        assign c[4*gj+2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & ci);
        assign c[4*gj+3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
                         | (gp[2] & gp[1] & gp[0] & ci);

        assign grp_p = &gp;
        assign grp_g = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
                     | (gp[3] & gp[2] & gp[1] & gg[0]);
        assign co    = grp_g | (grp_p & ci);
      end

      assign slice_sum  = p ^ c;
      assign slice_cout = g_grp[NG-1].co;

      // Stage register: valid, accumulated sum and carry advance on en.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          valid_q <= 1'b0;
          sum_q   <= '0;
          carry_q <= 1'b0;
        end else if (en) begin
          valid_q <= v_in;
          sum_q   <= sum_d;
          carry_q <= slice_cout;
        end
      end

      // Operand slices not yet added travel with the operation.
      if (gi < N - 1) begin : g_fwd
        logic [RW-CHUNK-1:0] a_fwd_q;
        logic [RW-CHUNK-1:0] b_fwd_q;
`ifdef PIPE_CLA_SUB_EN
        logic                sub_fwd_q;
`endif

        // Delayed operands shift alongside the stage register.
        always_ff @(posedge clk) begin
          if (!rst_n) begin
            a_fwd_q   <= '0;
            b_fwd_q   <= '0;
`ifdef PIPE_CLA_SUB_EN
            sub_fwd_q <= 1'b0;
`endif
          end else if (en) begin
            a_fwd_q   <= a_in[RW-1:CHUNK];
            b_fwd_q   <= b_in[RW-1:CHUNK];
`ifdef PIPE_CLA_SUB_EN
            sub_fwd_q <= sub_in;
`endif
          end
        end
      end

      if (gi == N - 1) begin : g_last
        logic ovf_q;

        // Signed overflow: carry out of the top bit XOR carry into it.
        always_ff @(posedge clk) begin
          if (!rst_n) begin
            ovf_q <= 1'b0;
          end else if (en) begin
            ovf_q <= slice_cout ^ c[CHUNK-1];
          end
        end
      end
    end
  endgenerate

  assign out_valid_w   = g_stage[N-1].valid_q;
  assign bus.out_valid = out_valid_w;
  assign bus.S         = g_stage[N-1].sum_q;
  assign bus.cout      = g_stage[N-1].carry_q;
  assign bus.ovf       = g_stage[N-1].g_last.ovf_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench for pipelined_cla_adder (WIDTH=32, CHUNK=16, N=2).
// Directed steps followed by a random phase; a scoreboard queue holds the
// expected result of every accepted operation. Define PIPE_CLA_SUB_EN to
// include the subtract checks.
module tb_pipelined_cla_adder;
  localparam int WIDTH = 32;
  localparam int CHUNK = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipelined_cla_adder_if #(.WIDTH(WIDTH)) bus ();

  pipelined_cla_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;
  logic [33:0] exp_q [$];   // {S, cout, ovf}

  // Reference: plain 33-bit addition with the sign rule for overflow.
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic c, input logic s);
    logic [31:0] bb;
    logic        cc;
    logic [32:0] r;
    logic        v;
    bb = s ? ~b : b;
    cc = s ? 1'b1 : c;
    r  = {1'b0, a} + {1'b0, bb} + {32'd0, cc};
    v  = (a[31] == bb[31]) && (r[31] != a[31]);
    return {r[31:0], r[32], v};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle of stimulus, driven #1 after a rising edge; returns the
  // in_ready seen before the edge and records the expected result if accepted.
  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic c, input logic s, input logic r, output logic rdy);
    logic s_eff;
    bus.in_valid  = v;
    bus.A         = a;
    bus.B         = b;
    bus.cin       = c;
    bus.out_ready = r;
`ifdef PIPE_CLA_SUB_EN
    bus.sub = s;
    s_eff   = s;
`else
    s_eff   = 1'b0 & s;
`endif
    #1;
    rdy = bus.in_ready;
    if (v && rdy && rst_n) exp_q.push_back(model(a, b, c, s_eff));
    @(posedge clk);
    #1;
  endtask

  task automatic idle(output logic rdy);
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, rdy);
  endtask

  // Latency-2 directed add/sub with constant expectations.
  task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic c, input logic s,
                          input logic [31:0] es, input logic ec, input logic eo);
    logic rdy;
    step(1'b1, a, b, c, s, 1'b1, rdy);
    chk({tag, " accept"}, rdy, 1);
    chk({tag, " not yet valid"}, bus.out_valid, 0);
    idle(rdy);
    chk({tag, " valid"}, bus.out_valid, 1);
    chk({tag, " S"}, bus.S, es);
    chk({tag, " cout"}, bus.cout, ec);
    chk({tag, " ovf"}, bus.ovf, eo);
    idle(rdy);
  endtask

  // Scoreboard: a result transfers on the next edge when valid and ready.
  always @(negedge clk) begin
    logic [33:0] e;
    if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      $display("[TB] result S=%h cout=%b ovf=%b", bus.S, bus.cout, bus.ovf);
      if (exp_q.size() == 0) begin
        chk("unexpected result", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("scoreboard result", {bus.S, bus.cout, bus.ovf}, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic rdy;
    bus.in_valid  = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b1;
`ifdef PIPE_CLA_SUB_EN
    bus.sub       = 1'b0;
`endif

    // Reset held two cycles with a valid all-ones operand set on the bus.
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, rdy);
      chk("reset in_ready", rdy, 1);
      chk("reset out_valid", bus.out_valid, 0);
      chk("reset S", bus.S, 0);
      chk("reset cout", bus.cout, 0);
      chk("reset ovf", bus.ovf, 0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle(rdy);
      chk("post-reset out_valid", bus.out_valid, 0);
      chk("post-reset in_ready", rdy, 1);
    end

    directed("carry across slices", 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0,
             32'h0001_0000, 1'b0, 1'b0);
    directed("full-width carry", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0,
             32'h0000_0000, 1'b1, 1'b0);
    directed("signed overflow", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0,
             32'h8000_0000, 1'b0, 1'b1);

    // Backpressure: 1+1, 2+2, 3+3 with out_ready low for 3 cycles.
    step(1'b1, 32'd1, 32'd1, 1'b0, 1'b0, 1'b1, rdy);
    chk("bp accept 1", rdy, 1);
    step(1'b1, 32'd2, 32'd2, 1'b0, 1'b0, 1'b1, rdy);
    chk("bp accept 2", rdy, 1);
    chk("bp first valid", bus.out_valid, 1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'd3, 32'd3, 1'b0, 1'b0, 1'b0, rdy);
      chk("bp hold in_ready", rdy, 0);
      chk("bp hold out_valid", bus.out_valid, 1);
      chk("bp hold S", bus.S, 2);
    end
    step(1'b1, 32'd3, 32'd3, 1'b0, 1'b0, 1'b1, rdy);
    chk("bp accept 3", rdy, 1);
    chk("bp second S", bus.S, 4);
    chk("bp second valid", bus.out_valid, 1);
    idle(rdy);
    chk("bp third S", bus.S, 6);
    chk("bp third valid", bus.out_valid, 1);
    idle(rdy);
    chk("bp drained", bus.out_valid, 0);

`ifdef PIPE_CLA_SUB_EN
    directed("sub 5-7", 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    directed("sub ovf", 32'h8000_0000, 32'd1, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
`endif

    // Reset mid-operation: the in-flight result must never appear.
    step(1'b1, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b1, rdy);
    rst_n = 1'b0;
    exp_q.delete();
    idle(rdy);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle(rdy);
      chk("mid-op reset no result", bus.out_valid, 0);
    end

    // Random traffic with random backpressure.
    for (int i = 0; i < 80; i++) begin
      step($urandom_range(0, 3) != 0, $urandom, $urandom, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, rdy);
    end
    for (int i = 0; i < 30 && exp_q.size() > 0; i++) idle(rdy);
    chk("scoreboard empty", exp_q.size(), 0);
    idle(rdy);
    chk("final out_valid", bus.out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
